// File: rtl/exe_mul_pkg.sv
// Shared types and constants for the EXE-stage sequential RV32M multiplier.
package exe_mul_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mul_state_t;

  localparam int MUL_ITERS = 32;

endpackage

// File: rtl/carry_lookahead_adder64.sv
// 64-bit parallel-prefix carry-lookahead adder, no carry-in, carry-out dropped.
module carry_lookahead_adder64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum
);

  logic [63:0] gk;
  logic [63:0] pk;

  // Kogge-Stone prefix: after the last level gk[i] is the carry out of bit i.
  always_comb begin
    gk = a & b;
    pk = a ^ b;
    for (int d = 1; d < 64; d = d * 2) begin
      gk = gk | (pk & (gk << d));
      pk = pk & (pk << d);
    end
    sum = a ^ b ^ {gk[62:0], 1'b0};
  end

endmodule

// File: rtl/exe_seq_multiplier.sv
// Multi-cycle RV32M multiplier: radix-2 shift-add over magnitudes, then sign fix.
//   state | meaning
//   IDLE  | waiting for start; done pulse may be high here
//   CALC  | one shift-add iteration per cycle, ITERS cycles
//   FIX   | conditional two's-complement of the product, result capture
module exe_seq_multiplier
  import exe_mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = MUL_ITERS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITERS);

  mul_state_t state, state_nxt;
  mul_op_t    op_q;
  logic [31:0]   mcand;
  logic [63:0]   prod;
  logic          neg;
  logic [CW-1:0] count;

  logic          a_signed, b_signed;
  logic [31:0]   a_mag, b_mag;
  logic [63:0]   add_a, add_b, add_sum;
  logic [32:0]   sum33;
  logic [63:0]   fix_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush) state_nxt = CALC;
      CALC: begin
        if (flush)                          state_nxt = IDLE;
        else if (count == CW'(ITERS - 1))   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == FIX);

  // Magnitudes use plain subtraction so the shared adder stays free.
  always_comb begin
    a_signed = (mul_op_t'(op) == MUL_HSS) || (mul_op_t'(op) == MUL_HSU);
    b_signed = (mul_op_t'(op) == MUL_HSS);
    a_mag    = (a_signed && a[31]) ? (32'd0 - a) : a;
    b_mag    = (b_signed && b[31]) ? (32'd0 - b) : b;
  end

  // One adder serves both phases: accumulate in CALC, negate in FIX.
  always_comb begin
    add_a = {32'd0, prod[63:32]};
    add_b = {32'd0, mcand};
    if (state == FIX) begin
      add_a = ~prod;
      add_b = 64'd1;
    end
  end

  carry_lookahead_adder64 u_cla (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  assign sum33 = prod[0] ? add_sum[32:0] : {1'b0, prod[63:32]};
  assign fix_p = neg ? add_sum : prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MUL_LO;
      mcand  <= '0;
      prod   <= '0;
      neg    <= 1'b0;
      count  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q  <= mul_op_t'(op);
            mcand <= a_mag;
            prod  <= {32'd0, b_mag};
            neg   <= (a_signed & a[31]) ^ (b_signed & b[31]);
            count <= '0;
          end
        end
        CALC: begin
          if (!flush) begin
            prod  <= {sum33, prod[31:1]};
            count <= count + CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            result <= (op_q == MUL_LO) ? fix_p[31:0] : fix_p[63:32];
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_seq_multiplier.sv
// Directed self-checking bench for exe_seq_multiplier.
module tb_exe_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_seq_multiplier dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the accepting edge E0 (cycle 1).
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    a     = '0;
    b     = '0;
  endtask

  // Expects done exactly 33 edges after E0, i.e. 34 cycles after the start cycle.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd33);
    chk({tag, "_res"}, result, exp);
  endtask

  task automatic watch_no_done(input string tag, input logic [31:0] exp_res);
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen++;
    end
    chk({tag, "_nodone"}, 32'(seen), 32'd0);
    chk({tag, "_res"}, result, exp_res);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required end before 100000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    // MUL 7*6 with cycle-exact busy/done, plus a start pulse while busy at cycle 5.
    issue(2'b00, 32'd7, 32'd6);
    for (int c = 1; c <= 33; c++) begin
      chk($sformatf("t1_busydone_c%0d", c), {30'd0, busy, done}, 32'b10);
      if (c == 5) begin
        start = 1'b1;
        op    = 2'b11;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
        a     = '0;
        b     = '0;
      end
      tick();
    end
    chk("t1_c34_busydone", {30'd0, busy, done}, 32'b01);
    chk("t1_c34_result", result, 32'd42);
    tick();
    chk("t1_c35_done", {31'd0, done}, 32'd0);
    chk("t1_c35_busy", {31'd0, busy}, 32'd0);

    issue(2'b01, 32'h8000_0000, 32'h8000_0000);
    wait_done("mulh_min", 32'h4000_0000);
    tick();
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done("mul_min", 32'h0000_0000);
    tick();
    issue(2'b01, 32'hFFFF_FFFD, 32'd5);
    wait_done("mulh_m3x5", 32'hFFFF_FFFF);
    tick();
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done("mul_m3x5", 32'hFFFF_FFF1);
    tick();
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhsu_ff", 32'hFFFF_FFFF);
    tick();

    // MULHU followed by a start in its done cycle: zero idle cycles.
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhu_ff", 32'hFFFF_FFFE);
    issue(2'b00, 32'd3, 32'd4);
    wait_done("b2b_3x4", 32'd12);
    tick();

    // Flush at cycle 10 of a MUL.
    issue(2'b00, 32'd5, 32'd5);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    watch_no_done("flush", 32'd12);

    // start together with flush in IDLE is dropped.
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b00;
    a     = 32'd3;
    b     = 32'd3;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("idleflush_busy", {31'd0, busy}, 32'd0);
    watch_no_done("idleflush", 32'd12);

    // Asynchronous reset in the middle of CALC.
    issue(2'b00, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_done", {31'd0, done}, 32'd0);
    chk("areset_result", result, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(2'b00, 32'h0001_0000, 32'h0001_0000);
    wait_done("mul_2p32", 32'd0);
    tick();
    issue(2'b11, 32'h0001_0000, 32'h0001_0000);
    wait_done("mulhu_2p32", 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
